top: RTL and testbench

- FPGA top level for the 25 MHz board.
- Samples six switch/button inputs (btn[6:1]) every cycle through a synchroniser.
- Keeps a 32-bit per-value hit counter in a 64-entry register file.
- Logs every change of the sampled value into a 256-word RAM, and shows the log write pointer on the LEDs.
- btn[0] is the system reset.

---
 rtl/top.sv | 151 +++++++++++++++
 tb/tb_top.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/top.sv
`timescale 1ns/1ps
// Board top for the 25 MHz target: synchronises six button inputs, counts hits per
// sampled value in a register file and logs every value change into a 256-word RAM.

module log_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i
);
    logic [WIDTH-1:0] Daten [0:DEPTH-1];

    // NOTE: block RAM storage is never reset; a reset loop would stop it mapping to a RAM primitive.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            Daten[addr_i] <= wdata_i;
        end
    end
endmodule

module register_file #(
    parameter int NUM_REGS  = 64,
    parameter int REG_WIDTH = 32,
    parameter int IW        = $clog2(NUM_REGS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [IW-1:0] idx_i
);
    logic [REG_WIDTH-1:0] registers [0:NUM_REGS-1];

    // Unlike the log RAM, the hit counters must clear on reset, so they live in flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                registers[i] <= '0;
            end
        end else begin
            registers[idx_i] <= registers[idx_i] + REG_WIDTH'(1);
        end
    end
endmodule

module cpu #(
    parameter int RAM_DEPTH = 256,
    parameter int NUM_REGS  = 64,
    parameter int REG_WIDTH = 32,
    parameter int AW        = $clog2(RAM_DEPTH),
    parameter int IW        = $clog2(NUM_REGS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IW-1:0]        data_i,
    output logic                 we_o,
    output logic [AW-1:0]        waddr_o,
    output logic [REG_WIDTH-1:0] wdata_o,
    output logic [AW-1:0]        wp_o
);
    logic [IW-1:0] s1_q, s2_q, prev_q, prev_d;
    logic [AW-1:0] wp_q, wp_d;
    logic          change;

    assign change = (s2_q != prev_q);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        prev_d = prev_q;
        wp_d   = wp_q;
        if (change) begin
            prev_d = s2_q;
            wp_d   = wp_q + AW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so s1 -> s2 behaves as a real two-flop chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            wp_q   <= '0;
        end else begin
            s1_q   <= data_i;
            s2_q   <= s1_q;
            prev_q <= prev_d;
            wp_q   <= wp_d;
        end
    end

    // A reset edge must not also commit a log entry.
    assign we_o    = change & ~rst_i;
    assign waddr_o = wp_q;
    assign wdata_o = {{(REG_WIDTH-IW){1'b0}}, s2_q};
    assign wp_o    = wp_q;

    register_file #(
        .NUM_REGS (NUM_REGS),
        .REG_WIDTH(REG_WIDTH)
    ) Register (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .idx_i(s2_q)
    );
endmodule

module top #(
    parameter int RAM_DEPTH = 256,
    parameter int NUM_REGS  = 64,
    parameter int REG_WIDTH = 32
) (
    input  logic       clk_25mhz,
    input  logic [6:0] btn,
    output logic [7:0] led
);
    localparam int AW = $clog2(RAM_DEPTH);

    logic                 we;
    logic [AW-1:0]        waddr;
    logic [REG_WIDTH-1:0] wdata;
    logic [AW-1:0]        wp;

    cpu #(
        .RAM_DEPTH(RAM_DEPTH),
        .NUM_REGS (NUM_REGS),
        .REG_WIDTH(REG_WIDTH)
    ) CPU (
        .clk_i  (clk_25mhz),
        .rst_i  (btn[0]),
        .data_i (btn[6:1]),
        .we_o   (we),
        .waddr_o(waddr),
        .wdata_o(wdata),
        .wp_o   (wp)
    );

    log_ram #(
        .DEPTH(RAM_DEPTH),
        .WIDTH(REG_WIDTH)
    ) ram (
        .clk_i  (clk_25mhz),
        .we_i   (we),
        .addr_i (waddr),
        .wdata_i(wdata)
    );

    assign led = wp;
endmodule

// File: tb/tb_top.sv
`timescale 1ns/1ps
// Randomised bench for top: a delay-line/history model of hit counts and the change log,
// compared against led every cycle and against the register file and RAM at checkpoints.

module tb_top;
    logic       clk_25mhz = 1'b0;
    logic [6:0] btn = 7'h01;
    logic [7:0] led;

    top dut (
        .clk_25mhz(clk_25mhz),
        .btn      (btn),
        .led      (led)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int vectors     = 0;
    int miscompares = 0;

    int unsigned m_regs [64];
    int unsigned m_ram  [256];
    int          m_wp   = 0;
    int          m_last = 0;
    int          pipe   [$];
    bit          checking = 1'b0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Value seen by the change detector is the one applied two edges earlier.
    task automatic model_edge(input logic [6:0] b);
        int cur;
        if (b[0]) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_wp   = 0;
            m_last = 0;
            pipe   = {0, 0};
        end else begin
            cur = pipe.pop_front();
            m_regs[cur] = m_regs[cur] + 1;
            if (cur != m_last) begin
                m_ram[m_wp] = cur;
                m_wp        = (m_wp + 1) % 256;
                m_last      = cur;
            end
            pipe.push_back(int'(b[6:1]));
        end
    endtask

    task automatic step(input logic [6:0] b);
        btn = b;
        @(posedge clk_25mhz);
        #1;
        model_edge(b);
        checking = 1'b1;
    endtask

    task automatic hold(input int v, input int n);
        for (int k = 0; k < n; k++) step({v[5:0], 1'b0});
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) step(7'h01);
    endtask

    task automatic full_compare(input string tag);
        for (int i = 0; i < 64; i++)
            check($sformatf("%s_reg%0d", tag, i), dut.CPU.Register.registers[i], m_regs[i]);
        for (int i = 0; i < 256; i++)
            check($sformatf("%s_ram%0d", tag, i), dut.ram.Daten[i], m_ram[i]);
        check({tag, "_led"}, led, m_wp);
    endtask

    always @(negedge clk_25mhz) begin
        if (checking) check("led_cycle", led, m_wp);
    end

    initial begin
        foreach (m_regs[i]) m_regs[i] = 0;
        foreach (m_ram[i])  m_ram[i]  = 0;
        pipe = {0, 0};

        // Reset, then zeros for 10 cycles
        do_reset(1);
        check("rst_led", led, 0);
        hold(0, 10);
        check("zero_reg0", dut.CPU.Register.registers[0], 10);
        check("zero_led", led, 0);
        check("zero_ram0", dut.ram.Daten[0], 0);
        full_compare("zero");

        // Value 5 held 5 cycles
        hold(5, 5);
        check("five_reg0", dut.CPU.Register.registers[0], 12);
        check("five_reg5", dut.CPU.Register.registers[5], 3);
        check("five_ram0", dut.ram.Daten[0], 5);
        check("five_led", led, 1);
        check("model_reg0", m_regs[0], 12);
        full_compare("five");

        // Sweep 0..63
        do_reset(1);
        hold(0, 5);
        for (int v = 1; v < 64; v++) hold(v, 5);
        check("sweep_led", led, 63);
        check("sweep_reg0", dut.CPU.Register.registers[0], 7);
        check("sweep_reg10", dut.CPU.Register.registers[10], 5);
        check("sweep_reg62", dut.CPU.Register.registers[62], 5);
        check("sweep_reg63", dut.CPU.Register.registers[63], 3);
        check("sweep_ram0", dut.ram.Daten[0], 1);
        check("sweep_ram62", dut.ram.Daten[62], 63);
        full_compare("sweep");

        // Alternate 1/2 for 257 changes: pointer wraps
        do_reset(1);
        for (int k = 0; k < 257; k++) hold((k % 2 == 0) ? 1 : 2, 5);
        check("alt_led", led, 1);
        check("alt_ram0", dut.ram.Daten[0], 1);
        check("alt_ram1", dut.ram.Daten[1], 2);
        full_compare("alt");

        // Mid-run reset for 3 cycles, RAM must survive
        hold(9, 5);
        hold(17, 5);
        hold(3, 2);
        do_reset(3);
        check("mid_led", led, 0);
        check("mid_ram1", dut.ram.Daten[1], 9);
        full_compare("mid");
        hold(22, 5);
        check("mid_next_ram0", dut.ram.Daten[0], 22);
        check("mid_next_led", led, 1);
        full_compare("midnext");

        // 0x2D held 100 cycles
        do_reset(1);
        hold(45, 100);
        check("hold_reg45", dut.CPU.Register.registers[45], 98);
        check("hold_ram0", dut.ram.Daten[0], 45);
        check("hold_led", led, 1);
        full_compare("hold");

        // Randomised segments with occasional resets
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
            else hold($urandom_range(0, 63), $urandom_range(1, 6));
        end
        full_compare("rand");

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
